// File: rtl/rv32i_exec_mem_unit_pkg.sv
// Shared constants and types for the RV32I execute/memory slice:
// data width, memory geometry, ALU operation codes and load func3 codes.
package rv32i_exec_mem_unit_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_LANES   = DATA_WIDTH / 8;
  localparam int MEM_DEPTH   = 1024;
  localparam int MEM_AW      = 10;
  localparam int BYTE_ADDR_W = 12;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  // Result for any alu_ctrl code outside the table above
  localparam logic [DATA_WIDTH-1:0] ALU_DEFAULT_RESULT = '0;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Lowest enabled byte lane; lane 0 when the mask is empty
  function automatic logic [1:0] first_lane(input logic [NUM_LANES-1:0] be);
    first_lane = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (be[i]) first_lane = 2'(i);
    end
  endfunction

endpackage

// File: rtl/rv32i_exec_mem_unit_if.sv
// Operand, memory-access and result bundle of the execute/memory slice.
// The unit itself takes the slave side; a driver takes the master side.
interface rv32i_exec_mem_unit_if;
  import rv32i_exec_mem_unit_pkg::*;

  logic [3:0]             alu_ctrl;
  logic                   alu_src;
  logic [DATA_WIDTH-1:0]  src1;
  logic [DATA_WIDTH-1:0]  src2;
  logic [DATA_WIDTH-1:0]  sign_ext;
  logic [DATA_WIDTH-1:0]  alu_results;
  logic                   alu_zero;
  logic                   alu_last_bit;
  logic [DATA_WIDTH-1:0]  w_dat;
  logic                   w_enb;
  logic [NUM_LANES-1:0]   byte_enb;
  logic                   r_enb;
  logic [2:0]             func3;
  logic [DATA_WIDTH-1:0]  r_dat;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   wb_valid;
  logic [BYTE_ADDR_W-1:0] debug_addr;
  logic [DATA_WIDTH-1:0]  debug_data;

  modport slave (
    input  alu_ctrl, alu_src, src1, src2, sign_ext,
    input  w_dat, w_enb, byte_enb, r_enb, func3, debug_addr,
    output alu_results, alu_zero, alu_last_bit,
    output r_dat, wb_data, wb_valid, debug_data
  );

  modport master (
    output alu_ctrl, alu_src, src1, src2, sign_ext,
    output w_dat, w_enb, byte_enb, r_enb, func3, debug_addr,
    input  alu_results, alu_zero, alu_last_bit,
    input  r_dat, wb_data, wb_valid, debug_data
  );

endinterface

// File: rtl/rv32i_exec_mem_unit_byte_lane_ram.sv
// Word array with per-byte write enables, one combinational access port
// and an independent combinational debug read port.
module byte_lane_ram
  import rv32i_exec_mem_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [NUM_LANES-1:0]  be_i,
  input  logic [MEM_AW-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [MEM_AW-1:0]     dbg_addr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] dbg_data_o
);

  // Power-up contents are zero; reset deliberately leaves the array alone
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH] = '{default: '0};

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o    = mem_q[addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/rv32i_exec_mem_unit.sv
// RV32I execute/memory slice: combinational ALU whose result addresses a
// byte-enabled data memory, followed by a load extender for write-back.
module rv32i_exec_mem_unit
  import rv32i_exec_mem_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rv32i_exec_mem_unit_if.slave bus
);

  logic [DATA_WIDTH-1:0] opb;
  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  alu_op_e               alu_op;

  assign opb    = bus.alu_src ? bus.sign_ext : bus.src2;
  assign shamt  = opb[4:0];
  assign alu_op = alu_op_e'(bus.alu_ctrl);

  always_comb begin
    alu_res = ALU_DEFAULT_RESULT;
    case (alu_op)
      ALU_ADD:  alu_res = bus.src1 + opb;
      ALU_SUB:  alu_res = bus.src1 - opb;
      ALU_AND:  alu_res = bus.src1 & opb;
      ALU_OR:   alu_res = bus.src1 | opb;
      ALU_XOR:  alu_res = bus.src1 ^ opb;
      ALU_SLL:  alu_res = bus.src1 << shamt;
      ALU_SRL:  alu_res = bus.src1 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(bus.src1) >>> shamt);
      ALU_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.src1) < $signed(opb)};
      ALU_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.src1 < opb};
      default:  alu_res = ALU_DEFAULT_RESULT;
    endcase
  end

  assign bus.alu_results  = alu_res;
  assign bus.alu_zero     = (alu_res == '0);
  assign bus.alu_last_bit = alu_res[0];

  // Address bits outside the word index are don't-care for the array
  logic       unused_addr_bits;
  logic       wr_en;
  logic [DATA_WIDTH-1:0] mem_word;
  logic [DATA_WIDTH-1:0] r_dat_w;

  assign unused_addr_bits = ^{alu_res[DATA_WIDTH-1:BYTE_ADDR_W], alu_res[1:0],
                              bus.debug_addr[1:0]};
  // rst is only sampled by the array at the clock edge, so gating here keeps reset synchronous
  assign wr_en = rst & bus.w_enb;

  byte_lane_ram u_ram (
    .clk_i      (clk),
    .wr_en_i    (wr_en),
    .be_i       (bus.byte_enb),
    .addr_i     (alu_res[BYTE_ADDR_W-1:2]),
    .wdata_i    (bus.w_dat),
    .dbg_addr_i (bus.debug_addr[BYTE_ADDR_W-1:2]),
    .rdata_o    (mem_word),
    .dbg_data_o (bus.debug_data)
  );

  assign r_dat_w   = (rst && bus.r_enb) ? mem_word : '0;
  assign bus.r_dat = r_dat_w;

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        wb_valid_c;
  logic [DATA_WIDTH-1:0] wb_data_c;

  assign lane     = first_lane(bus.byte_enb);
  assign byte_sel = r_dat_w[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? r_dat_w[31:16] : r_dat_w[15:0];
  assign is_byte  = $onehot(bus.byte_enb);
  assign is_half  = (bus.byte_enb == 4'b0011) || (bus.byte_enb == 4'b1100);
  assign is_word  = (bus.byte_enb == 4'b1111);

  always_comb begin
    wb_valid_c = 1'b0;
    wb_data_c  = '0;
    if (rst) begin
      case (bus.func3)
        F3_LB: if (is_byte) begin
          wb_valid_c = 1'b1;
          wb_data_c  = {{24{byte_sel[7]}}, byte_sel};
        end
        F3_LBU: if (is_byte) begin
          wb_valid_c = 1'b1;
          wb_data_c  = {24'b0, byte_sel};
        end
        F3_LH: if (is_half) begin
          wb_valid_c = 1'b1;
          wb_data_c  = {{16{half_sel[15]}}, half_sel};
        end
        F3_LHU: if (is_half) begin
          wb_valid_c = 1'b1;
          wb_data_c  = {16'b0, half_sel};
        end
        F3_LW: if (is_word) begin
          wb_valid_c = 1'b1;
          wb_data_c  = r_dat_w;
        end
        default: begin
          wb_valid_c = 1'b0;
          wb_data_c  = '0;
        end
      endcase
    end
  end

  assign bus.wb_valid = wb_valid_c;
  assign bus.wb_data  = wb_data_c;

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Directed plus randomized bench for rv32i_exec_mem_unit against a
// behavioural ALU / memory / load-extension model.
module tb_rv32i_exec_mem_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_exec_mem_unit_if bus ();

  rv32i_exec_mem_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [1024];
  logic [3:0]  be_tab [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return $unsigned($signed(a) >>> sh);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic load_model(input logic [31:0] word, input logic [3:0] be, input logic [2:0] f3,
                            output logic v, output logic [31:0] d);
    int n;
    int lo;
    logic [31:0] sh;
    n  = $countones(be);
    lo = 0;
    while (lo < 4 && !be[lo]) lo++;
    sh = (lo < 4) ? (word >> (8 * lo)) : 32'd0;
    v  = 1'b0;
    d  = 32'd0;
    case (f3)
      3'b000: if (n == 1) begin v = 1'b1; d = {{24{sh[7]}}, sh[7:0]}; end
      3'b100: if (n == 1) begin v = 1'b1; d = {24'd0, sh[7:0]}; end
      3'b001: if (be == 4'b0011 || be == 4'b1100) begin v = 1'b1; d = {{16{sh[15]}}, sh[15:0]}; end
      3'b101: if (be == 4'b0011 || be == 4'b1100) begin v = 1'b1; d = {16'd0, sh[15:0]}; end
      3'b010: if (be == 4'b1111) begin v = 1'b1; d = word; end
      default: ;
    endcase
  endtask

  // Check all outputs against the model, then clock one edge and apply any write
  task automatic step(input string tag);
    logic [31:0] b, addr, rexp, wexp;
    logic        vexp;
    #2;
    b    = bus.alu_src ? bus.sign_ext : bus.src2;
    addr = alu_model(bus.alu_ctrl, bus.src1, b);
    chk({tag, ".alu"},  bus.alu_results, addr);
    chk({tag, ".zero"}, {31'd0, bus.alu_zero}, {31'd0, addr == 32'd0});
    chk({tag, ".lsb"},  {31'd0, bus.alu_last_bit}, {31'd0, addr[0]});
    rexp = (rst && bus.r_enb) ? ref_mem[addr[11:2]] : 32'd0;
    chk({tag, ".rdat"}, bus.r_dat, rexp);
    load_model(rexp, bus.byte_enb, bus.func3, vexp, wexp);
    if (!rst) begin
      vexp = 1'b0;
      wexp = 32'd0;
    end
    chk({tag, ".wbdat"}, bus.wb_data, wexp);
    chk({tag, ".wbval"}, {31'd0, bus.wb_valid}, {31'd0, vexp});
    chk({tag, ".dbg"},   bus.debug_data, ref_mem[bus.debug_addr[11:2]]);
    @(posedge clk);
    #1;
    if (rst && bus.w_enb) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byte_enb[i]) ref_mem[addr[11:2]][8*i +: 8] = bus.w_dat[8*i +: 8];
      end
    end
  endtask

  task automatic set_alu(input logic [3:0] op, input logic asrc, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] se);
    bus.alu_ctrl = op;
    bus.alu_src  = asrc;
    bus.src1     = s1;
    bus.src2     = s2;
    bus.sign_ext = se;
  endtask

  task automatic set_mem(input logic we, input logic [31:0] wd, input logic [3:0] be,
                         input logic re, input logic [2:0] f3, input logic [11:0] dbg);
    bus.w_enb      = we;
    bus.w_dat      = wd;
    bus.byte_enb   = be;
    bus.r_enb      = re;
    bus.func3      = f3;
    bus.debug_addr = dbg;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    be_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0110};

    // Reset: write to 0x0 is suppressed, reads and load results forced to zero
    rst = 1'b0;
    set_alu(4'b0000, 1'b1, 32'd0, 32'd0, 32'd0);
    set_mem(1'b1, 32'hDEADBEEF, 4'b1111, 1'b1, 3'b010, 12'h000);
    @(posedge clk);
    #1;
    #1;
    chk("rst.rdat",  bus.r_dat, 32'd0);
    chk("rst.wbval", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst.wbdat", bus.wb_data, 32'd0);
    step("rst");
    step("rst2");
    rst = 1'b1;
    set_mem(1'b0, 32'd0, 4'b1111, 1'b1, 3'b010, 12'h000);
    #1;
    chk("rst.mem0",  bus.debug_data, 32'd0);
    step("post_rst");

    // SLTU / SLT with 5 vs 0xFFFFFFFF
    set_alu(4'b1001, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF);
    #1;
    chk("sltu.res",  bus.alu_results, 32'd1);
    chk("sltu.zero", {31'd0, bus.alu_zero}, 32'd0);
    chk("sltu.lsb",  {31'd0, bus.alu_last_bit}, 32'd1);
    step("sltu");
    set_alu(4'b1000, 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF);
    #1;
    chk("slt.res",  bus.alu_results, 32'd0);
    chk("slt.zero", {31'd0, bus.alu_zero}, 32'd1);
    step("slt");
    set_alu(4'b0000, 1'b1, 32'd0, 32'd0, 32'd5);
    #1;
    chk("add.res", bus.alu_results, 32'd5);
    step("add");
    set_alu(4'b0001, 1'b0, 32'd3, 32'd3, 32'd0);
    #1;
    chk("sub.zero", {31'd0, bus.alu_zero}, 32'd1);
    step("sub");
    set_alu(4'b1111, 1'b0, 32'h1234, 32'h5, 32'd0);
    #1;
    chk("badop.res", bus.alu_results, 32'd0);
    step("badop");

    // Word store at 0xC, then debug reads of 0xC and 0x4
    set_alu(4'b0000, 1'b1, 32'h0000000C, 32'd0, 32'd0);
    set_mem(1'b1, 32'h00000001, 4'b1111, 1'b1, 3'b010, 12'h00C);
    #1;
    chk("sw.old", bus.r_dat, 32'd0);
    step("sw");
    set_mem(1'b0, 32'd0, 4'b1111, 1'b1, 3'b010, 12'h00C);
    #1;
    chk("sw.dbg_c", bus.debug_data, 32'h00000001);
    step("sw_rd");
    bus.debug_addr = 12'h004;
    #1;
    chk("sw.dbg_4", bus.debug_data, 32'd0);
    step("sw_rd4");

    // Byte store to lane 1 of 0x8, then signed / unsigned / illegal loads
    set_alu(4'b0000, 1'b1, 32'h00000008, 32'd0, 32'd0);
    set_mem(1'b1, 32'h00008000, 4'b0010, 1'b1, 3'b000, 12'h008);
    step("sb");
    set_mem(1'b0, 32'd0, 4'b0010, 1'b1, 3'b000, 12'h008);
    #1;
    chk("lb.data",  bus.wb_data, 32'hFFFFFF80);
    chk("lb.valid", {31'd0, bus.wb_valid}, 32'd1);
    step("lb");
    bus.func3 = 3'b100;
    #1;
    chk("lbu.data", bus.wb_data, 32'h00000080);
    step("lbu");
    bus.func3 = 3'b011;
    #1;
    chk("f3_011.valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("f3_011.data",  bus.wb_data, 32'd0);
    step("f3_011");

    // Randomized mix of ALU ops, byte-lane stores/loads and reset pulses
    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 1) == 1) begin
        set_alu(4'($urandom_range(0, 15)), 1'($urandom), $urandom, $urandom, $urandom);
      end else begin
        set_alu(4'd0, 1'b1, ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2),
                $urandom, 32'($urandom_range(0, 3)));
      end
      set_mem(1'($urandom), $urandom, be_tab[$urandom_range(0, 7)],
              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              12'((32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3))));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
